// File: rtl/unified_mem_responder_pkg.sv
// Shared encodings for the unified instruction/data memory responder.
package unified_mem_responder_pkg;

  // Data access size encodings (memsizesel)
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Arbiter priority state: which requester wins when both are valid
  typedef enum logic {
    PRI_I = 1'b0,
    PRI_D = 1'b1
  } arb_state_t;

endpackage

// File: rtl/unified_mem_responder_lane_fmt.sv
// Purely combinational lane formatting: store byte-enables and lane
// replication, misalignment detection, and load lane select/extension.
module mem_lane_fmt
  import unified_mem_responder_pkg::*;
(
  input  logic [1:0]  req_size_i,
  input  logic [1:0]  req_lane_i,
  input  logic [31:0] req_wdata_i,
  output logic        req_err_o,
  output logic [3:0]  req_be_o,
  output logic [31:0] req_wdata_o,
  input  logic [1:0]  rsp_size_i,
  input  logic [1:0]  rsp_lane_i,
  input  logic        rsp_unsigned_i,
  input  logic [31:0] rsp_word_i,
  output logic [31:0] rsp_data_o
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Request side: alignment check, lane enables, store data replicated to every lane
  always_comb begin
    req_err_o   = 1'b0;
    req_be_o    = 4'b0000;
    req_wdata_o = req_wdata_i;
    case (req_size_i)
      SZ_WORD: begin
        req_err_o = (req_lane_i != 2'b00);
        req_be_o  = 4'b1111;
      end
      SZ_BYTE: begin
        req_be_o    = 4'b0001 << req_lane_i;
        req_wdata_o = {4{req_wdata_i[7:0]}};
      end
      SZ_HALF: begin
        req_err_o   = req_lane_i[0];
        req_be_o    = req_lane_i[1] ? 4'b1100 : 4'b0011;
        req_wdata_o = {2{req_wdata_i[15:0]}};
      end
      default: req_err_o = 1'b1;
    endcase
    // An erroring request must never touch the array
    if (req_err_o) begin
      req_be_o = 4'b0000;
    end
  end

  // Response side: pick the addressed lane and sign/zero extend it
  always_comb begin
    case (rsp_lane_i)
      2'd0:    sel_byte = rsp_word_i[7:0];
      2'd1:    sel_byte = rsp_word_i[15:8];
      2'd2:    sel_byte = rsp_word_i[23:16];
      default: sel_byte = rsp_word_i[31:24];
    endcase
    sel_half = rsp_lane_i[1] ? rsp_word_i[31:16] : rsp_word_i[15:0];
    case (rsp_size_i)
      SZ_BYTE: rsp_data_o = rsp_unsigned_i ? {24'b0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      SZ_HALF: rsp_data_o = rsp_unsigned_i ? {16'b0, sel_half} : {{16{sel_half[15]}}, sel_half};
      default: rsp_data_o = rsp_word_i;
    endcase
  end

endmodule

// File: rtl/unified_mem_responder.sv
// Single-ported unified memory serving an instruction-fetch port and a data
// port with alternating-priority arbitration and a two-edge response pipeline
// (array read register, then formatted output register).
module unified_mem_responder
  import unified_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  input  logic [31:0] i_req_addr,
  output logic        i_req_ready,
  output logic        i_rsp_valid,
  output logic [31:0] i_rsp_data,
  input  logic        d_req_valid,
  input  logic        d_req_we,
  input  logic [1:0]  d_req_size,
  input  logic        d_req_unsigned,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  output logic        d_req_ready,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_rdata,
  output logic        d_rsp_err
);

  logic [31:0] mem_q [DEPTH_WORDS];
  arb_state_t  arb_q, arb_d;

  logic             grant_i, grant_d;
  logic [IDX_W-1:0] acc_idx;
  logic             req_err;
  logic [3:0]       req_be;
  logic [31:0]      req_wdata;
  logic [31:0]      ld_data;

  logic [31:0] rword_q;
  logic        s1_i_q, s1_d_q, s1_we_q, s1_err_q, s1_uns_q;
  logic [1:0]  s1_size_q, s1_lane_q;

  logic        i_rsp_valid_q, d_rsp_valid_q, d_rsp_err_q;
  logic [31:0] i_rsp_data_q, d_rsp_rdata_q;

  // Address bits above the array and fetch sub-word bits do not select storage
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_req_addr[31:IDX_W+2], i_req_addr[1:0], d_req_addr[31:IDX_W+2]};

  // Grant: a lone requester always wins; on contention the priority state decides
  always_comb begin
    grant_i = i_req_valid && !rst && (!d_req_valid || arb_q == PRI_I);
    grant_d = d_req_valid && !rst && !grant_i;
    arb_d   = arb_q;
    if (grant_i) begin
      arb_d = PRI_D;
    end else if (grant_d) begin
      arb_d = PRI_I;
    end
    acc_idx = grant_i ? i_req_addr[IDX_W+1:2] : d_req_addr[IDX_W+1:2];
  end

  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;

  mem_lane_fmt u_lane_fmt (
    .req_size_i     (d_req_size),
    .req_lane_i     (d_req_addr[1:0]),
    .req_wdata_i    (d_req_wdata),
    .req_err_o      (req_err),
    .req_be_o       (req_be),
    .req_wdata_o    (req_wdata),
    .rsp_size_i     (s1_size_q),
    .rsp_lane_i     (s1_lane_q),
    .rsp_unsigned_i (s1_uns_q),
    .rsp_word_i     (rword_q),
    .rsp_data_o     (ld_data)
  );

  // Arbiter priority state, returns to instruction priority on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      arb_q <= PRI_I;
    end else begin
      arb_q <= arb_d;
    end
  end

  // Array: byte-enabled store and registered read for the granted request (never reset)
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (grant_d && d_req_we && req_be[b]) begin
        mem_q[acc_idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
    if (grant_i || grant_d) begin
      rword_q <= mem_q[acc_idx];
    end
  end

  // First pipeline stage: remember who was granted and how to format the reply
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_i_q    <= 1'b0;
      s1_d_q    <= 1'b0;
      s1_we_q   <= 1'b0;
      s1_err_q  <= 1'b0;
      s1_uns_q  <= 1'b0;
      s1_size_q <= SZ_WORD;
      s1_lane_q <= 2'b00;
    end else begin
      s1_i_q    <= grant_i;
      s1_d_q    <= grant_d;
      s1_we_q   <= d_req_we;
      s1_err_q  <= req_err;
      s1_uns_q  <= d_req_unsigned;
      s1_size_q <= d_req_size;
      s1_lane_q <= d_req_addr[1:0];
    end
  end

  // Registered responses; stores and errors return zero data
  always_ff @(posedge clk) begin
    if (rst) begin
      i_rsp_valid_q <= 1'b0;
      i_rsp_data_q  <= '0;
      d_rsp_valid_q <= 1'b0;
      d_rsp_err_q   <= 1'b0;
      d_rsp_rdata_q <= '0;
    end else begin
      i_rsp_valid_q <= s1_i_q;
      i_rsp_data_q  <= s1_i_q ? rword_q : '0;
      d_rsp_valid_q <= s1_d_q;
      d_rsp_err_q   <= s1_d_q && s1_err_q;
      d_rsp_rdata_q <= (s1_d_q && !s1_we_q && !s1_err_q) ? ld_data : '0;
    end
  end

  assign i_rsp_valid = i_rsp_valid_q;
  assign i_rsp_data  = i_rsp_data_q;
  assign d_rsp_valid = d_rsp_valid_q;
  assign d_rsp_err   = d_rsp_err_q;
  assign d_rsp_rdata = d_rsp_rdata_q;

endmodule

// File: tb/tb_unified_mem_responder.sv
// Self-checking bench: directed scenarios followed by random traffic, all
// compared against a byte-level reference model with a response queue.
module tb_unified_mem_responder;

  logic        clk;
  logic        rst;
  logic        i_req_valid;
  logic [31:0] i_req_addr;
  logic        i_req_ready;
  logic        i_rsp_valid;
  logic [31:0] i_rsp_data;
  logic        d_req_valid;
  logic        d_req_we;
  logic [1:0]  d_req_size;
  logic        d_req_unsigned;
  logic [31:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic        d_req_ready;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_rdata;
  logic        d_rsp_err;

  unified_mem_responder #(.DEPTH_WORDS(4096)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_req_valid    (i_req_valid),
    .i_req_addr     (i_req_addr),
    .i_req_ready    (i_req_ready),
    .i_rsp_valid    (i_rsp_valid),
    .i_rsp_data     (i_rsp_data),
    .d_req_valid    (d_req_valid),
    .d_req_we       (d_req_we),
    .d_req_size     (d_req_size),
    .d_req_unsigned (d_req_unsigned),
    .d_req_addr     (d_req_addr),
    .d_req_wdata    (d_req_wdata),
    .d_req_ready    (d_req_ready),
    .d_rsp_valid    (d_rsp_valid),
    .d_rsp_rdata    (d_rsp_rdata),
    .d_rsp_err      (d_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_i;
    logic [31:0] data;
    logic        err;
    int          due;
  } rsp_t;

  int          nvec = 0;
  int          nerr = 0;
  int          edge_cnt = 0;
  int          txn = 0;
  int          d_seen = 0;
  bit          pri_i = 1'b1;
  logic [31:0] mmem [4096];
  rsp_t        pend [$];
  logic [31:0] last_d;
  logic        last_err;
  logic [3:0]  obs_log;

  localparam logic [31:0] ADDR_MASK = 32'hFFFF_C03F;

  // Reference data operation on the model memory
  task automatic data_op(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err);
    int unsigned idx;
    int unsigned sh;
    logic [31:0] w;
    logic [31:0] v;
    idx = (a / 4) % 4096;
    sh  = 8 * (a % 4);
    err = (sz == 2'd3) || (sz == 2'd2 && a[0]) || (sz == 2'd0 && (a % 4) != 0);
    rd  = 32'd0;
    if (!err) begin
      w = mmem[idx];
      if (we) begin
        case (sz)
          2'd0: w = wd;
          2'd1: w = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
          default: w = (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
        endcase
        mmem[idx] = w;
      end else begin
        case (sz)
          2'd0: rd = w;
          2'd1: begin
            v = (w >> sh) & 32'hFF;
            if (!uns && v >= 128) v = v - 256;
            rd = v;
          end
          default: begin
            v = (w >> sh) & 32'hFFFF;
            if (!uns && v >= 32768) v = v - 65536;
            rd = v;
          end
        endcase
      end
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] ia, input logic dv, input logic we,
                       input logic [1:0] sz, input logic uns, input logic [31:0] da,
                       input logic [31:0] wd);
    i_req_valid    = iv;
    i_req_addr     = ia;
    d_req_valid    = dv;
    d_req_we       = we;
    d_req_size     = sz;
    d_req_unsigned = uns;
    d_req_addr     = da;
    d_req_wdata    = wd;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
      tick();
    end
  endtask

  // One clock: check grants, update model, advance, check responses
  task automatic tick();
    logic        gi, gd, exp_iv, exp_dv;
    logic [31:0] rd;
    logic        er;
    rsp_t        e;
    #1;
    gi = 1'b0;
    gd = 1'b0;
    if (!rst) begin
      if (i_req_valid && (!d_req_valid || pri_i)) gi = 1'b1;
      else if (d_req_valid) gd = 1'b1;
    end
    nvec++;
    assert ({i_req_ready, d_req_ready} === {gi, gd}) else begin
      nerr++;
      $error("FAIL ready: observed i=%b d=%b expected i=%b d=%b", i_req_ready, d_req_ready, gi, gd);
    end
    obs_log = {obs_log[2:0], i_req_ready};
    if (gi) begin
      pri_i = 1'b0;
      e.is_i = 1'b1;
      e.data = mmem[(i_req_addr / 4) % 4096];
      e.err  = 1'b0;
      e.due  = edge_cnt + 2;
      pend.push_back(e);
      txn++;
      $display("txn %0d: fetch addr=%h", txn, i_req_addr);
    end
    if (gd) begin
      pri_i = 1'b1;
      data_op(d_req_we, d_req_size, d_req_unsigned, d_req_addr, d_req_wdata, rd, er);
      e.is_i = 1'b0;
      e.data = rd;
      e.err  = er;
      e.due  = edge_cnt + 2;
      pend.push_back(e);
      txn++;
      $display("txn %0d: data we=%b size=%0d uns=%b addr=%h wdata=%h", txn, d_req_we,
               d_req_size, d_req_unsigned, d_req_addr, d_req_wdata);
    end
    @(posedge clk);
    edge_cnt++;
    if (rst) begin
      pend.delete();
      pri_i = 1'b1;
    end
    @(negedge clk);
    exp_iv = 1'b0;
    exp_dv = 1'b0;
    if (pend.size() > 0 && pend[0].due == edge_cnt) begin
      e = pend.pop_front();
      exp_iv = e.is_i;
      exp_dv = !e.is_i;
    end
    nvec++;
    assert ({i_rsp_valid, d_rsp_valid} === {exp_iv, exp_dv}) else begin
      nerr++;
      $error("FAIL rsp_valid: observed i=%b d=%b expected i=%b d=%b", i_rsp_valid, d_rsp_valid,
             exp_iv, exp_dv);
    end
    if (exp_iv) begin
      nvec++;
      assert (i_rsp_data === e.data) else begin
        nerr++;
        $error("FAIL i_rsp_data: observed %h expected %h", i_rsp_data, e.data);
      end
    end
    if (exp_dv) begin
      nvec++;
      assert ({d_rsp_err, d_rsp_rdata} === {e.err, e.data}) else begin
        nerr++;
        $error("FAIL d_rsp: observed err=%b data=%h expected err=%b data=%h", d_rsp_err,
               d_rsp_rdata, e.err, e.data);
      end
    end
    if (d_rsp_valid) begin
      last_d   = d_rsp_rdata;
      last_err = d_rsp_err;
      d_seen++;
    end
  endtask

  task automatic check_d(input string tag, input logic err, input logic [31:0] data);
    nvec++;
    assert ({last_err, last_d} === {err, data}) else begin
      nerr++;
      $error("FAIL %s: observed err=%b data=%h expected err=%b data=%h", tag, last_err, last_d,
             err, data);
    end
  endtask

  initial begin
    int seen_before;
    obs_log = 4'b0;
    last_d = 32'd0;
    last_err = 1'b0;
    rst = 1'b1;
    drive(1'b1, 32'd0, 1'b1, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    tick();
    tick();
    nvec++;
    assert ({i_rsp_valid, d_rsp_valid, d_rsp_err, i_rsp_data, d_rsp_rdata} === 67'd0) else begin
      nerr++;
      $error("FAIL reset_outputs: observed iv=%b dv=%b err=%b idata=%h drdata=%h expected all zero",
             i_rsp_valid, d_rsp_valid, d_rsp_err, i_rsp_data, d_rsp_rdata);
    end
    rst = 1'b0;

    // Give the low words known contents
    for (int w = 0; w < 16; w++) begin
      drive(1'b0, 32'd0, 1'b1, 1'b1, 2'd0, 1'b0, 32'(w * 4), $urandom);
      tick();
    end
    idle(2);

    // Contention after reset: grants alternate starting with fetch
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h8, 1'b1, 1'b0, 2'd0, 1'b0, 32'h4, 32'd0);
      tick();
    end
    nvec++;
    assert (obs_log === 4'b1010) else begin
      nerr++;
      $error("FAIL grant_order: observed %b expected %b", obs_log, 4'b1010);
    end
    idle(2);

    // Byte merge into a stored word
    drive(1'b0, 0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h100, 32'hDEADBEEF); tick();
    drive(1'b0, 0, 1'b1, 1'b1, 2'd1, 1'b0, 32'h101, 32'h55); tick();
    drive(1'b0, 0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h100, 0); tick();
    idle(2);
    check_d("byte_merge", 1'b0, 32'hDEAD55EF);

    // Sign and zero extension
    drive(1'b0, 0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h200, 32'h0000_80F0); tick();
    drive(1'b0, 0, 1'b1, 1'b0, 2'd1, 1'b0, 32'h200, 0); tick();
    idle(2);
    check_d("lb_signed", 1'b0, 32'hFFFF_FFF0);
    drive(1'b0, 0, 1'b1, 1'b0, 2'd1, 1'b1, 32'h200, 0); tick();
    idle(2);
    check_d("lb_unsigned", 1'b0, 32'h0000_00F0);
    drive(1'b0, 0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h200, 0); tick();
    idle(2);
    check_d("lh_signed", 1'b0, 32'hFFFF_80F0);

    // Misaligned half store and reserved size both error without writing
    drive(1'b0, 0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h203, 32'h1234); tick();
    idle(2);
    check_d("sh_misaligned", 1'b1, 32'd0);
    drive(1'b0, 0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h200, 0); tick();
    idle(2);
    check_d("after_err_load", 1'b0, 32'h0000_80F0);
    drive(1'b0, 0, 1'b1, 1'b0, 2'd3, 1'b0, 32'h200, 0); tick();
    idle(2);
    check_d("size_rsvd", 1'b1, 32'd0);

    // Address wrap modulo the array
    drive(1'b0, 0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0000_4000, 32'hA5C3_0F96); tick();
    drive(1'b0, 0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 0); tick();
    idle(2);
    check_d("wrap", 1'b0, 32'hA5C3_0F96);

    // Fetch right after a store sees the new word (misaligned fetch address)
    drive(1'b0, 0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h10, 32'h0BAD_F00D); tick();
    drive(1'b1, 32'h12, 1'b0, 1'b0, 2'd0, 1'b0, 0, 0); tick();
    idle(2);

    // Reset right after a data grant swallows its response and restores fetch priority
    drive(1'b0, 0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h20, 0); tick();
    seen_before = d_seen;
    rst = 1'b1;
    drive(1'b1, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h20, 0); tick();
    rst = 1'b0;
    idle(3);
    nvec++;
    assert (d_seen === seen_before) else begin
      nerr++;
      $error("FAIL rst_drop: observed %0d responses expected %0d", d_seen, seen_before);
    end
    drive(1'b1, 32'h4, 1'b1, 1'b0, 2'd0, 1'b0, 32'h8, 0);
    tick();
    nvec++;
    assert (obs_log[0] === 1'b1) else begin
      nerr++;
      $error("FAIL rst_priority: observed i_grant=%b expected %b", obs_log[0], 1'b1);
    end
    idle(2);

    // Random traffic against the model
    for (int k = 0; k < 300; k++) begin
      drive(1'($urandom_range(0, 1)), $urandom & ADDR_MASK, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom & ADDR_MASK, $urandom);
      tick();
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
